// File: rtl/play_timer.sv
// Elapsed-playback MM:SS timer in BCD: a prescaler divides clk down to seconds,
// and a start/pause/clear FSM gates counting. Every output comes straight from a flop.
module play_timer #(
  parameter  int TICK_DIV = 50000000,
  localparam int PW       = $clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       tick,
  output logic       overflow,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [3:0]    r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
  logic [3:0]    w_sec_ones_nxt, w_sec_tens_nxt, w_min_ones_nxt, w_min_tens_nxt;
  logic          r_running, r_tick, r_overflow;
  logic          w_adv, w_ovf_nxt;

  // Priority clear > pause > start. pause outside RUN still blocks start.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_adv       = 1'b0;
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_presc_nxt = '0;
    end else if (pause) begin
      if (r_state == S_RUN) w_state_nxt = S_PAUSE;
    end else if (r_state == S_RUN) begin
      if (r_presc == PRESC_MAX) begin
        w_presc_nxt = '0;
        w_adv       = 1'b1;
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end else if (start) begin
      w_state_nxt = S_RUN;
    end
  end

  // One-edge BCD ripple; carry out of min_tens flags the 99:59 -> 00:00 wrap.
  always_comb begin
    w_sec_ones_nxt = r_sec_ones;
    w_sec_tens_nxt = r_sec_tens;
    w_min_ones_nxt = r_min_ones;
    w_min_tens_nxt = r_min_tens;
    w_ovf_nxt      = 1'b0;
    if (clear) begin
      w_sec_ones_nxt = 4'd0;
      w_sec_tens_nxt = 4'd0;
      w_min_ones_nxt = 4'd0;
      w_min_tens_nxt = 4'd0;
    end else if (w_adv) begin
      if (r_sec_ones != 4'd9) begin
        w_sec_ones_nxt = r_sec_ones + 4'd1;
      end else begin
        w_sec_ones_nxt = 4'd0;
        if (r_sec_tens != 4'd5) begin
          w_sec_tens_nxt = r_sec_tens + 4'd1;
        end else begin
          w_sec_tens_nxt = 4'd0;
          if (r_min_ones != 4'd9) begin
            w_min_ones_nxt = r_min_ones + 4'd1;
          end else begin
            w_min_ones_nxt = 4'd0;
            if (r_min_tens != 4'd9) begin
              w_min_tens_nxt = r_min_tens + 4'd1;
            end else begin
              w_min_tens_nxt = 4'd0;
              w_ovf_nxt      = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_presc    <= '0;
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_min_tens <= 4'd0;
      r_running  <= 1'b0;
      r_tick     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_presc    <= w_presc_nxt;
      r_sec_ones <= w_sec_ones_nxt;
      r_sec_tens <= w_sec_tens_nxt;
      r_min_ones <= w_min_ones_nxt;
      r_min_tens <= w_min_tens_nxt;
      r_running  <= (w_state_nxt == S_RUN);
      r_tick     <= w_adv;
      r_overflow <= w_ovf_nxt;
    end
  end

  assign sec_ones  = r_sec_ones;
  assign sec_tens  = r_sec_tens;
  assign min_ones  = r_min_ones;
  assign min_tens  = r_min_tens;
  assign running   = r_running;
  assign tick      = r_tick;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule
